// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic inter-stage buffer with valid/ready handshake.
//   Holds up to DEPTH payloads so upstream keeps issuing while downstream stalls.
//   An empty stage presents BUBBLE on out_data. flush squashes every entry.
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/bubble/flush counters.
// Ports:
//   clk, rst (async, active high), flush (sync squash)
//   in_valid/in_ready/in_data    upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and head payload
//   count                        entries currently held
//   perf_*_cnt                   PIPE_PERF_CNT_EN builds only
module pipe_stage_fifo #(
    parameter int                 DATA_W = 160,
    parameter int                 DEPTH  = 2,
    parameter logic [DATA_W-1:0]  BUBBLE = '0,
    parameter int                 CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]              perf_stall_cnt,
    output logic [CNT_W-1:0]              perf_bubble_cnt,
    output logic [CNT_W-1:0]              perf_flush_cnt
`endif
);

    // DEPTH=1 still needs a 1-bit pointer; it simply never leaves 0.
    localparam int                     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                     CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CNT_BITS-1:0]    FULL     = CNT_BITS'(DEPTH);
    localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends on registered state only, never on out_ready, so a
    // full stage refuses a push even when a pop happens on the same edge.
    assign in_ready  = !rst && (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // A concurrent pop is still a completed transfer for downstream;
            // a concurrent push is dropped.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately not reset; out_data masks it with BUBBLE.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, bubble_q, flushc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flushc_q <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_q))  stall_q  <= stall_q + 1'b1;
            if (!out_valid && out_ready && !(&bubble_q)) bubble_q <= bubble_q + 1'b1;
            if (flush && out_valid && !(&flushc_q))      flushc_q <= flushc_q + 1'b1;
        end
    end

    assign perf_stall_cnt  = stall_q;
    assign perf_bubble_cnt = bubble_q;
    assign perf_flush_cnt  = flushc_q;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
module tb_pipe_stage_fifo;

    localparam logic [15:0] BUB = 16'hB0B0;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] in_data;

    always #5 clk = ~clk;

    logic        ir2, ov2, ir4, ov4;
    logic [15:0] od2, od4;
    logic [1:0]  c2;
    logic [2:0]  c4;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]  ps2, pb2, pf2, ps4, pb4, pf4;
`endif

    pipe_stage_fifo #(.DATA_W(16), .DEPTH(2), .BUBBLE(BUB), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(c2)
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall_cnt(ps2), .perf_bubble_cnt(pb2), .perf_flush_cnt(pf2)
`endif
    );

    pipe_stage_fifo #(.DATA_W(16), .DEPTH(4), .BUBBLE(BUB), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .count(c4)
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall_cnt(ps4), .perf_bubble_cnt(pb4), .perf_flush_cnt(pf4)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference: each stage is an ordered queue bounded by its depth.
    logic [15:0] mq [2][$];
    int          dep [2] = '{2, 4};
    int          mps [2], mpb [2], mpf [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mps[i] = 0; mpb[i] = 0; mpf[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic        ov [2];
        logic        ir [2];
        logic [15:0] od [2];
        logic [2:0]  ct [2];
        ov[0] = ov2; ov[1] = ov4; ir[0] = ir2; ir[1] = ir4;
        od[0] = od2; od[1] = od4; ct[0] = {1'b0, c2}; ct[1] = c4;
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = mq[i].size();
            chk({tag, "_valid"}, 32'(ov[i]), 32'(sz != 0));
            chk({tag, "_data"}, 32'(od[i]), 32'((sz != 0) ? mq[i][0] : BUB));
            chk({tag, "_count"}, 32'(ct[i]), 32'(sz));
            chk({tag, "_in_ready"}, 32'(ir[i]), 32'(!rst && sz < dep[i]));
            chk({tag, "_count_bound"}, 32'(ct[i] <= 3'(dep[i])), 32'd1);
        end
`ifdef PIPE_PERF_CNT_EN
        chk({tag, "_stall2"}, 32'(ps2), 32'(mps[0]));
        chk({tag, "_bubble2"}, 32'(pb2), 32'(mpb[0]));
        chk({tag, "_flush2"}, 32'(pf2), 32'(mpf[0]));
        chk({tag, "_stall4"}, 32'(ps4), 32'(mps[1]));
        chk({tag, "_bubble4"}, 32'(pb4), 32'(mpb[1]));
        chk({tag, "_flush4"}, 32'(pf4), 32'(mpf[1]));
`endif
    endtask

    // One clock edge: advance the model from the inputs held across the edge,
    // then compare both stages shortly after the edge.
    task automatic cycle(input string tag);
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = mq[i].size();
            if (rst) begin
                mq[i].delete();
                mps[i] = 0; mpb[i] = 0; mpf[i] = 0;
            end else begin
                if (sz != 0 && !out_ready && mps[i] < 15) mps[i]++;
                if (sz == 0 && out_ready && mpb[i] < 15)  mpb[i]++;
                if (flush && sz != 0 && mpf[i] < 15)      mpf[i]++;
                if (flush) mq[i].delete();
                else begin
                    if (sz != 0 && out_ready) void'(mq[i].pop_front());
                    if (in_valid && sz < dep[i]) mq[i].push_back(in_data);
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  ec;
        logic        eir;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_clear();
        #1;
        chk("reset_valid", 32'(ov2), 32'd0);
        chk("reset_data", 32'(od2), 32'(BUB));
        chk("reset_count", 32'(c2), 32'd0);
        chk("reset_in_ready", 32'(ir2), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(ir2), 32'd1);

        // Expected columns are for the DEPTH=2 stage.
        // back-to-back A,B,C with out_ready=1
        tbl.push_back('{1'b1, 16'h000A, 1'b1, 1'b0, 1'b1, 16'h000A, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h000B, 1'b1, 1'b0, 1'b1, 16'h000B, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000C, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, BUB,      2'd0, 1'b1});
        // fill with downstream stalled; third push refused
        tbl.push_back('{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0002, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, BUB,      2'd0, 1'b1});
        // flush at count=2 with a push offered, then at count=1 with a push accepted
        tbl.push_back('{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0005, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h0005, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 16'h0007, 1'b0, 1'b1, 1'b0, BUB,      2'd0, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, BUB,      2'd0, 1'b1});
        tbl.push_back('{1'b1, 16'h0008, 1'b0, 1'b0, 1'b1, 16'h0008, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 16'h0009, 1'b0, 1'b1, 1'b0, BUB,      2'd0, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, BUB,      2'd0, 1'b1});

        foreach (tbl[k]) begin
            in_valid = tbl[k].iv; in_data = tbl[k].d;
            out_ready = tbl[k].ordy; flush = tbl[k].fl;
            cycle("vec");
            chk("tbl_valid", 32'(ov2), 32'(tbl[k].ev));
            chk("tbl_data", 32'(od2), 32'(tbl[k].ed));
            chk("tbl_count", 32'(c2), 32'(tbl[k].ec));
            chk("tbl_in_ready", 32'(ir2), 32'(tbl[k].eir));
        end
        flush = 1'b0;

        // async reset mid-stream at count=2
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = 16'h0011; cycle("pre_rst");
        in_data = 16'h0022; cycle("pre_rst");
        chk("pre_rst_count", 32'(c2), 32'd2);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_async_valid", 32'(ov2), 32'd0);
        chk("rst_async_data", 32'(od2), 32'(BUB));
        chk("rst_async_count", 32'(c2), 32'd0);
        chk("rst_async_in_ready", 32'(ir2), 32'd0);
        in_valid = 1'b0;
        cycle("in_rst");
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(ir2), 32'd1);
        cycle("post_rst");

`ifdef PIPE_PERF_CNT_EN
        rst = 1'b1; model_clear(); #1; rst = 1'b0;
        in_valid = 1'b1; in_data = 16'h0033; out_ready = 1'b0;
        cycle("perf_push");
        in_valid = 1'b0;
        repeat (20) cycle("perf_stall");
        chk("perf_stall_sat", 32'(ps2), 32'd15);
        flush = 1'b1;
        cycle("perf_flush");
        flush = 1'b0;
        chk("perf_flush_one", 32'(pf2), 32'd1);
        cycle("perf_idle");
        chk("perf_flush_hold", 32'(pf2), 32'd1);
`endif

        // randomized traffic, with phases biased towards filling and draining
        for (int n = 0; n < 600; n++) begin
            int bias;
            bias = (n / 50) % 3;
            in_valid  = ($urandom_range(0, 3) < (bias == 1 ? 1 : 3));
            out_ready = ($urandom_range(0, 3) < (bias == 0 ? 1 : 3));
            flush     = ($urandom_range(0, 39) == 0);
            in_data   = 16'($urandom);
            cycle("rand");
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cycle("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
